// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO-side and serial-side signal bundle for fifo_uart_tx
interface fifo_uart_tx_if;
  logic       enable;
  logic       empty;
  logic [7:0] DATAIN;
  logic       rn;
  logic       tx;
  logic       busy;
  logic       done;

  // Driver of the FIFO/control inputs (FIFO model, system controller)
  modport master (
    output enable, empty, DATAIN,
    input  rn, tx, busy, done
  );

  // The transmitter itself
  modport slave (
    input  enable, empty, DATAIN,
    output rn, tx, busy, done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a byte FIFO and shifts each byte out as a UART frame
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clock,
  input  logic          reset,
  fifo_uart_tx_if.slave bus
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_MAX  = 1'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic          stop_cnt;
  logic          baud_last;

  assign baud_last = (baud_cnt == BAUD_MAX);

  // State register; reset abandons any frame in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; outputs depend only on registered state
  always_comb begin
    state_nxt = state;
    bus.rn    = 1'b0;
    bus.tx    = 1'b1;
    bus.busy  = 1'b1;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.enable && !bus.empty) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        bus.rn    = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = START;
      end
      START: begin
        bus.tx = 1'b0;
        if (baud_last) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        bus.tx = shift[0];
        if (baud_last && (bit_cnt == 3'd7)) begin
          state_nxt = HAS_PAR ? PARITY : STOP;
        end
      end
      PARITY: begin
        bus.tx = par_bit;
        if (baud_last) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (baud_last && (stop_cnt == STOP_MAX)) begin
          bus.done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Baud/bit/stop counters and shift register; parity is latched at load
  // because the shift register is consumed as the bits go out
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
      par_bit  <= 1'b0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          shift    <= bus.DATAIN;
          par_bit  <= ^bus.DATAIN;
          baud_cnt <= '0;
          bit_cnt  <= 3'd0;
          stop_cnt <= 1'b0;
        end
        START, PARITY: begin
          baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
        end
        DATA: begin
          baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
          if (baud_last) begin
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        STOP: begin
          baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
          if (baud_last) begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          baud_cnt <= '0;
          bit_cnt  <= 3'd0;
          stop_cnt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx in two frame formats
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en[2];
  logic       wn[2];
  logic [7:0] wdata[2];
  logic       tx_a[2];
  logic       rn_a[2];
  logic       busy_a[2];
  logic       done_a[2];
  int         rn_cnt[2];
  int         frames[2];
  int         done_cnt[2];
  int         aborted[2];
  int         pushed[2];
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clock = ~clock;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level line value for cycle k of a frame carrying byte b
  function automatic logic exp_tx(input logic [7:0] b, input int k, input int par);
    int idx;
    idx = k / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (par != 0 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int PAR = (gi == 0) ? 0 : 1;
    localparam int SB  = gi + 1;
    localparam int L   = (9 + PAR + SB) * CPB;

    fifo_uart_tx_if bus ();

    fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PAR),
      .STOP_BITS   (SB)
    ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
    );

    assign bus.enable = en[gi];
    assign tx_a[gi]   = bus.tx;
    assign rn_a[gi]   = bus.rn;
    assign busy_a[gi] = bus.busy;
    assign done_a[gi] = bus.done;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    initial begin
      bus.empty  = 1'b1;
      bus.DATAIN = 8'd0;
    end

    // FIFO harness: registered empty, data valid the cycle after the pop
    always @(posedge clock) begin
      if (wn[gi]) begin
        fifo_q.push_back(wdata[gi]);
        exp_q.push_back(wdata[gi]);
      end
      if (bus.rn && fifo_q.size() > 0) bus.DATAIN <= fifo_q.pop_front();
      bus.empty <= (fifo_q.size() == 0);
    end

    bit         in_frame = 1'b0;
    bit         pend = 1'b0;
    bit         b2b = 1'b0;
    int         k = 0;
    int         ferr = 0;
    int         since_rn = 100;
    int         since_done = 100;
    logic [7:0] cur = 8'd0;
    logic [7:0] rx = 8'd0;

    // Monitor: decode the serial line and compare against the scoreboard
    always @(negedge clock) begin
      if (!reset) begin
        if (in_frame) aborted[gi]++;
        else if (pend) begin
          void'(exp_q.pop_front());
          aborted[gi]++;
        end
        in_frame   = 1'b0;
        pend       = 1'b0;
        b2b        = 1'b0;
        since_rn   = 100;
        since_done = 100;
      end else begin
        since_rn++;
        since_done++;
        if (bus.done) done_cnt[gi]++;
        if (bus.rn) begin
          chk(fifo_q.size() > 0, "rn_nonempty", fifo_q.size(), 1);
          rn_cnt[gi]++;
          pend     = 1'b1;
          since_rn = 0;
        end
        if (!in_frame) begin
          if (since_done == 1) chk(bus.busy == 1'b0, "busy_fall", int'(bus.busy), 0);
          if (bus.tx == 1'b0) begin
            chk(since_rn == 2, "start_latency", since_rn, 2);
            if (b2b) chk(since_done == 4, "interframe_gap", since_done, 4);
            chk(exp_q.size() > 0, "start_expected", exp_q.size(), 1);
            cur      = (exp_q.size() > 0) ? exp_q.pop_front() : 8'd0;
            in_frame = 1'b1;
            k        = 0;
            ferr     = 0;
            rx       = 8'd0;
            pend     = 1'b0;
            b2b      = 1'b0;
          end
        end
        if (in_frame) begin
          if (bus.tx !== exp_tx(cur, k, PAR)) ferr++;
          if (bus.busy !== 1'b1) ferr++;
          if (bus.done !== (k == L - 1)) ferr++;
          if ((k % CPB) == CPB / 2 && (k / CPB) >= 1 && (k / CPB) <= 8) rx[k/CPB-1] = bus.tx;
          if (k == L - 1) begin
            chk(ferr == 0, "frame_cycles", ferr, 0);
            chk(rx == cur, "rx_byte", int'(rx), int'(cur));
            frames[gi]++;
            in_frame   = 1'b0;
            since_done = 0;
            b2b        = (fifo_q.size() > 0) && en[gi];
          end
          k++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] b);
    wn[i]    = 1'b1;
    wdata[i] = b;
    step(1);
    wn[i] = 1'b0;
    pushed[i]++;
  endtask

  task automatic wait_frames(input int i, input int n, input int budget);
    int c;
    c = 0;
    while (frames[i] < n && c < budget) begin
      step(1);
      c++;
    end
    chk(frames[i] >= n, "frames_reached", frames[i], n);
  endtask

  task automatic wait_rn(input int i, input int n, input int budget);
    int c;
    c = 0;
    while (rn_cnt[i] < n && c < budget) begin
      step(1);
      c++;
    end
    chk(rn_cnt[i] >= n, "rn_reached", rn_cnt[i], n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int r0;
    int f0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; wn[i] = 1'b0; wdata[i] = 8'd0;
      rn_cnt[i] = 0; frames[i] = 0; done_cnt[i] = 0; aborted[i] = 0; pushed[i] = 0;
    end

    // Asynchronous reset at power-up
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(tx_a[i] === 1'b1, "rst_tx", int'(tx_a[i]), 1);
      chk(rn_a[i] === 1'b0, "rst_rn", int'(rn_a[i]), 0);
      chk(busy_a[i] === 1'b0, "rst_busy", int'(busy_a[i]), 0);
      chk(done_a[i] === 1'b0, "rst_done", int'(done_a[i]), 0);
    end
    step(3);
    reset = 1'b1;
    step(2);

    // Empty guard
    en[0] = 1'b1; en[1] = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++)
        if (rn_a[i] !== 1'b0 || busy_a[i] !== 1'b0 || tx_a[i] !== 1'b1) bad++;
    end
    chk(bad == 0, "empty_guard", bad, 0);
    step(1);

    // Single byte 100 in both formats
    push(0, 8'd100);
    push(1, 8'd100);
    wait_frames(0, 1, 200);
    wait_frames(1, 1, 200);
    step(5);
    chk(busy_a[0] == 1'b0 && busy_a[1] == 1'b0, "single_idle", int'(busy_a[0]) + int'(busy_a[1]), 0);

    // Back-to-back drain
    en[0] = 1'b0;
    push(0, 8'd100);
    push(0, 8'd150);
    push(0, 8'd200);
    r0 = rn_cnt[0];
    f0 = frames[0];
    en[0] = 1'b1;
    wait_frames(0, f0 + 3, 400);
    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0) bad++;
    end
    step(1);
    chk(rn_cnt[0] == r0 + 3, "b2b_rn_count", rn_cnt[0] - r0, 3);
    chk(bad == 0, "b2b_idle_line", bad, 0);

    // Reset in the middle of the data bits
    r0 = rn_cnt[0];
    push(0, 8'h5A);
    wait_rn(0, r0 + 1, 50);
    step(2 + 3 * CPB);
    chk(busy_a[0] === 1'b1, "pre_reset_busy", int'(busy_a[0]), 1);
    reset = 1'b0;
    #1;
    chk(tx_a[0] === 1'b1, "midrst_tx", int'(tx_a[0]), 1);
    chk(rn_a[0] === 1'b0, "midrst_rn", int'(rn_a[0]), 0);
    chk(busy_a[0] === 1'b0, "midrst_busy", int'(busy_a[0]), 0);
    chk(done_a[0] === 1'b0, "midrst_done", int'(done_a[0]), 0);
    step(3);
    reset = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0) bad++;
    end
    step(1);
    chk(bad == 0, "post_reset_idle", bad, 0);

    // Enable gating
    r0 = rn_cnt[0];
    f0 = frames[0];
    push(0, 8'd40);
    push(0, 8'd70);
    wait_rn(0, r0 + 1, 50);
    en[0] = 1'b0;
    wait_frames(0, f0 + 1, 200);
    step(30);
    chk(rn_cnt[0] == r0 + 1, "gate_no_rn", rn_cnt[0] - r0, 1);
    en[0] = 1'b1;
    wait_frames(0, f0 + 2, 200);

    // Randomized traffic into both formats
    for (int j = 0; j < 16; j++) begin
      int i;
      i = int'($urandom_range(0, 1));
      push(i, 8'($urandom_range(0, 255)));
      step(int'($urandom_range(0, 40)));
    end
    for (int i = 0; i < 2; i++) wait_frames(i, pushed[i] - aborted[i], 3000);
    step(10);

    for (int i = 0; i < 2; i++) begin
      chk(done_cnt[i] == frames[i], "done_per_frame", done_cnt[i], frames[i]);
      chk(rn_cnt[i] == frames[i] + aborted[i], "rn_per_byte", rn_cnt[i], frames[i] + aborted[i]);
      chk(frames[i] + aborted[i] == pushed[i], "all_sent", frames[i] + aborted[i], pushed[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
